// File: rtl/ip_builder.sv
// IPv4 packet builder: computes the header checksum, emits a 20-byte header,
// then forwards the transport payload with length/EOF consistency checking.
//
// state   | meaning
// IDLE    | waiting for tx_start; rejects bad lengths with an ip_err pulse
// CSUM    | 10 word additions plus one cycle storing the inverted sum
// HEADER  | streaming header bytes 0..19 to the MAC
// PAYLOAD | forwarding payload bytes with 1-cycle latency
// FLUSH   | discarding surplus payload until pl_eof
module ip_builder #(
   parameter logic [7:0]  TRANSPORT_PROTOCOL = 8'd17,
   parameter logic [31:0] SRC_IP_ADDRESS     = 32'hC0A8_0001,
   parameter logic [7:0]  TTL                = 8'd64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_start,
   input  logic [15:0] tx_len,
   input  logic [31:0] tx_dest_ip,
   output logic        tx_busy,
   input  logic [7:0]  pl_data_in,
   input  logic        pl_byte_valid,
   input  logic        pl_eof,
   output logic        pl_ready,
   output logic [7:0]  ip_data_out,
   output logic        ip_byte_valid,
   input  logic        ip_ready,
   output logic        ip_eof,
   output logic        ip_err
);

   typedef enum logic [2:0] {IDLE, CSUM, HEADER, PAYLOAD, FLUSH} state_t;

   state_t      state_q, state_d;
   logic [4:0]  step_q;
   logic [16:0] acc_q;
   logic [15:0] csum_q;
   logic [15:0] tot_len_q;
   logic [15:0] len_q;
   logic [15:0] pl_cnt_q;
   logic [15:0] ident_q;
   logic [15:0] cur_ident_q;
   logic [31:0] dest_q;

   logic        can_load;
   logic        len_ok;
   logic        pl_acc;
   logic        pl_last;
   logic [3:0]  word_idx;
   logic [15:0] hdr_word;
   logic [7:0]  hdr_byte;
   logic [15:0] acc_final;

   assign can_load  = !ip_byte_valid || ip_ready;
   assign len_ok    = (tx_len != 16'd0) && (tx_len <= 16'd1480);
   assign pl_acc    = pl_byte_valid && pl_ready;
   assign pl_last   = (pl_cnt_q + 16'd1) == len_q;
   assign acc_final = acc_q[15:0] + {15'd0, acc_q[16]};

   // CSUM walks words, HEADER walks bytes; csum_q is zero while summing
   assign word_idx = (state_q == CSUM) ? step_q[3:0] : step_q[4:1];

   always_comb begin
      hdr_word = 16'h0000;
      case (word_idx)
         4'd0: hdr_word = 16'h4500;
         4'd1: hdr_word = tot_len_q;
         4'd2: hdr_word = cur_ident_q;
         4'd3: hdr_word = 16'h4000;
         4'd4: hdr_word = {TTL, TRANSPORT_PROTOCOL};
         4'd5: hdr_word = csum_q;
         4'd6: hdr_word = SRC_IP_ADDRESS[31:16];
         4'd7: hdr_word = SRC_IP_ADDRESS[15:0];
         4'd8: hdr_word = dest_q[31:16];
         4'd9: hdr_word = dest_q[15:0];
         default: hdr_word = 16'h0000;
      endcase
   end

   assign hdr_byte = step_q[0] ? hdr_word[7:0] : hdr_word[15:8];

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tx_start && len_ok) state_d = CSUM;
         CSUM:    if (step_q == 5'd10) state_d = HEADER;
         HEADER:  if (can_load && step_q == 5'd19) state_d = PAYLOAD;
         PAYLOAD: if (pl_acc) begin
                     if (pl_eof)       state_d = IDLE;
                     else if (pl_last) state_d = FLUSH;
                  end
         FLUSH:   if (pl_byte_valid && pl_eof) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_busy  = (state_q != IDLE);
      pl_ready = 1'b0;
      case (state_q)
         PAYLOAD: pl_ready = can_load;
         FLUSH:   pl_ready = 1'b1;
         default: pl_ready = 1'b0;
      endcase
   end

   // Carry out of bit 16 is folded back on the following add, so acc_q never overflows
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_q      <= 5'd0;
         acc_q       <= 17'd0;
         csum_q      <= 16'd0;
         tot_len_q   <= 16'd0;
         len_q       <= 16'd0;
         pl_cnt_q    <= 16'd0;
         ident_q     <= 16'd0;
         cur_ident_q <= 16'd0;
         dest_q      <= 32'd0;
      end else begin
         case (state_q)
            IDLE: if (tx_start && len_ok) begin
               len_q       <= tx_len;
               dest_q      <= tx_dest_ip;
               tot_len_q   <= tx_len + 16'd20;
               cur_ident_q <= ident_q;
               ident_q     <= ident_q + 16'd1;
               acc_q       <= 17'd0;
               csum_q      <= 16'd0;
               step_q      <= 5'd0;
               pl_cnt_q    <= 16'd0;
            end
            CSUM: if (step_q == 5'd10) begin
               csum_q <= ~acc_final;
               step_q <= 5'd0;
            end else begin
               acc_q  <= {1'b0, acc_q[15:0]} + {16'd0, acc_q[16]} + {1'b0, hdr_word};
               step_q <= step_q + 5'd1;
            end
            HEADER: if (can_load) step_q <= (step_q == 5'd19) ? 5'd0 : step_q + 5'd1;
            PAYLOAD: if (pl_acc) pl_cnt_q <= pl_cnt_q + 16'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ip_data_out   <= 8'd0;
         ip_byte_valid <= 1'b0;
         ip_eof        <= 1'b0;
         ip_err        <= 1'b0;
      end else if (can_load) begin
         ip_byte_valid <= 1'b0;
         ip_eof        <= 1'b0;
         ip_err        <= 1'b0;
         case (state_q)
            IDLE: ip_err <= tx_start && !len_ok;
            HEADER: begin
               ip_data_out   <= hdr_byte;
               ip_byte_valid <= 1'b1;
            end
            PAYLOAD: if (pl_acc) begin
               ip_data_out   <= pl_data_in;
               ip_byte_valid <= 1'b1;
               ip_eof        <= pl_eof || pl_last;
               ip_err        <= pl_eof ^ pl_last;
            end
            default: ;
         endcase
      end
   end

endmodule
